osc_clkdiv_mgr: RTL and testbench
=================================

// Module: osc_clkdiv_mgr
// PURPOSE
//  Manages the on-chip oscillator. Drives osc_dis through a power-up/standby FSM
//  with a settle counter, then produces NUM_CH independently programmable divided
//  clocks and clock-enable strobes for the SoC peripheral domains.
//  clk is an always-on reference clock. The block only gates the oscillator; it
//  never gates its own clock.
// PARAMETERS
//  NUM_CH      2    number of divider channels (1..8)
//  DIV_W       8    divide-ratio field width per channel; channel period = D+1 cycles
//  SETTLE_CYC  16   clk cycles spent in WARMUP after osc_dis deasserts (>=1)
//  RESET_DIV   1    divide ratio D loaded into every channel at reset (< 2**DIV_W)
// PORTS
//  clk          in   1            reference clock, rising edge
//  rst_n        in   1            asynchronous active-low reset
//  stby_req_i   in   1            1 = request oscillator standby, 0 = request run
//  osc_dis_o    out  1            to oscillator primitive osc_dis; 1 = disabled
//  osc_ready_o  out  1            1 while FSM is in RUN
//  ch_en_i      in   NUM_CH       per-channel run enable
//  cfg_valid_i  in   NUM_CH       per-channel new-ratio valid
//  cfg_ready_o  out  NUM_CH       per-channel shadow register free
//  div_cfg_i    in   NUM_CH*DIV_W new ratio D, channel i at [i*DIV_W +: DIV_W]
//  clk_en_o     out  NUM_CH       1-cycle strobe on the last cycle of each period
//  div_clk_o    out  NUM_CH       registered divided clock
// BEHAVIOUR
//  Reset (async, while rst_n=0): FSM=OFF, osc_dis_o=1, osc_ready_o=0, cnt=0,
//   active ratio=RESET_DIV, shadows empty, cfg_ready_o=all 1, clk_en_o=0,
//   div_clk_o=0. Reset mid-operation aborts everything immediately.
//  FSM: OFF -> WARMUP when stby_req_i=0 (osc_dis_o=0 from the WARMUP cycle on).
//   WARMUP counts SETTLE_CYC cycles -> RUN (osc_ready_o=1 on the first RUN cycle).
//   WARMUP ignores stby_req_i until the count completes; then goes to DRAIN if
//   stby_req_i=1, otherwise RUN.
//   RUN -> DRAIN when stby_req_i=1. DRAIN -> OFF once every channel is idle.
//   DRAIN always completes; stby_req_i=0 in DRAIN has no effect until OFF.
//   osc_ready_o=0 in OFF, WARMUP and DRAIN. osc_dis_o=1 only in OFF.
//  Channel i is active only in RUN with ch_en_i[i]=1.
//   cnt counts 0..D and wraps to 0.
//   clk_en_o[i]=1 exactly when cnt==D.
//   div_clk_o[i]=1 for cnt < ceil((D+1)/2), 0 otherwise; both outputs are registered.
//   D=0 gives clk_en_o=1 every cycle and div_clk_o=1 constant.
//  Stop (ch_en_i low or FSM leaves RUN): the current period completes, including the
//   final clk_en_o strobe. The channel then idles with cnt=0, clk_en_o=0 and
//   div_clk_o=0. An idle channel restarts at cnt=0 the cycle after its enable
//   condition returns. No runt high or low phase is ever produced.
//  Config: a transfer occurs when cfg_valid_i[i] & cfg_ready_o[i]; the value goes to
//   shadow and cfg_ready_o[i] drops the next cycle. The shadow is applied at the next
//   period boundary (cnt==D cycle, new D effective from cnt=0), or on the next cycle if
//   the channel is idle. cfg_ready_o[i] rises the cycle after the shadow is applied.
//   A transfer on the same cycle as a boundary is applied at the following boundary.
//  Channels are fully independent. No arithmetic overflow: cnt is DIV_W bits and never
//   exceeds D.
// TESTING
//  T1 reset release, stby_req_i=0, SETTLE_CYC=16 -> osc_dis_o falls 1 cycle after
//   reset, osc_ready_o rises exactly 16 cycles later.
//  T2 RUN, D=3, ch_en=1 -> clk_en_o pulses every 4th cycle, div_clk_o 2 high / 2 low;
//   D=4 -> 3 high / 2 low; D=0 -> clk_en_o stuck 1.
//  T3 D=3, write D=7 mid-period -> cfg_ready_o low, current period stays 4 cycles, next
//   period 8 cycles, cfg_ready_o re-rises 1 cycle after the boundary.
//  T4 stby_req_i=1 with ch0 D=9 at cnt=2, ch1 disabled -> DRAIN 8 cycles,
//   ch0 final strobe, then OFF, osc_dis_o=1.
//  T5 toggle ch_en_i low at cnt=1 (D=5) -> period finishes, idle 0; re-enable
//   -> first strobe 6 cycles later.
//  T6 assert rst_n=0 mid-RUN and mid-DRAIN -> all outputs reach reset values
//   without a clock edge.

Source files
------------

// File: rtl/osc_clkdiv_mgr.sv
// Oscillator power-up/standby sequencer with NUM_CH programmable clock dividers.
// Each channel emits a registered divided clock and a last-cycle enable strobe.
module osc_clkdiv_mgr #(
   parameter int NUM_CH     = 2,
   parameter int DIV_W      = 8,
   parameter int SETTLE_CYC = 16,
   parameter int RESET_DIV  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stby_req_i,
   output logic                    osc_dis_o,
   output logic                    osc_ready_o,
   input  logic [NUM_CH-1:0]       ch_en_i,
   input  logic [NUM_CH-1:0]       cfg_valid_i,
   output logic [NUM_CH-1:0]       cfg_ready_o,
   input  logic [NUM_CH*DIV_W-1:0] div_cfg_i,
   output logic [NUM_CH-1:0]       clk_en_o,
   output logic [NUM_CH-1:0]       div_clk_o
);

   typedef enum logic [1:0] {S_OFF, S_WARMUP, S_RUN, S_DRAIN} state_e;

   localparam int                SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [DIV_W-1:0]  RST_D       = DIV_W'(RESET_DIV);

   state_e        state_q;
   logic [SW-1:0] settle_q;
   logic          osc_dis_q, osc_ready_q;

   logic [NUM_CH-1:0]            run_q, run_d;
   logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_d;
   logic [NUM_CH-1:0][DIV_W-1:0] shd_q, shd_d;
   logic [NUM_CH-1:0]            full_q, full_d;
   logic [NUM_CH-1:0]            clk_en_q, clk_en_d;
   logic [NUM_CH-1:0]            div_clk_q, div_clk_d;
   logic [NUM_CH-1:0]            ch_act;
   logic                         all_idle;

   // High phase length is ceil((D+1)/2); one extra bit keeps D = 2**DIV_W-1 safe.
   function automatic logic [DIV_W:0] half_of(input logic [DIV_W-1:0] d);
      return ({1'b0, d} + (DIV_W+1)'(2)) >> 1;
   endfunction

   assign ch_act   = (state_q == S_RUN) ? ch_en_i : '0;
   assign all_idle = ~|run_q;

   // NOTE: async reset forces every state bit, including the shadow registers, so a
   // reset mid-operation cannot leave a half-applied ratio behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_OFF;
         settle_q    <= '0;
         osc_dis_q   <= 1'b1;
         osc_ready_q <= 1'b0;
      end else begin
         case (state_q)
            S_OFF: if (!stby_req_i) begin
               state_q   <= S_WARMUP;
               settle_q  <= '0;
               osc_dis_q <= 1'b0;
            end
            S_WARMUP: if (settle_q == SETTLE_LAST) begin
               if (stby_req_i) state_q <= S_DRAIN;
               else begin
                  state_q     <= S_RUN;
                  osc_ready_q <= 1'b1;
               end
            end else begin
               settle_q <= settle_q + SW'(1);
            end
            S_RUN: if (stby_req_i) begin
               state_q     <= S_DRAIN;
               osc_ready_q <= 1'b0;
            end
            S_DRAIN: if (all_idle) begin
               state_q   <= S_OFF;
               osc_dis_q <= 1'b1;
            end
            default: state_q <= S_OFF;
         endcase
      end
   end

   // NOTE: combinational next-state uses blocking assignments with defaults first,
   // so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      run_d     = run_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      shd_d     = shd_q;
      full_d    = full_q;
      clk_en_d  = '0;
      div_clk_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (run_q[i]) begin
            if (cnt_q[i] == div_q[i]) begin
               cnt_d[i] = '0;
               run_d[i] = ch_act[i];
               if (full_q[i]) begin
                  div_d[i]  = shd_q[i];
                  full_d[i] = 1'b0;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
         end else begin
            cnt_d[i] = '0;
            run_d[i] = ch_act[i];
            if (full_q[i]) begin
               div_d[i]  = shd_q[i];
               full_d[i] = 1'b0;
            end
         end
         // Only accepted while the shadow was empty, so it never collides with an apply.
         if (cfg_valid_i[i] && !full_q[i]) begin
            shd_d[i]  = div_cfg_i[i*DIV_W +: DIV_W];
            full_d[i] = 1'b1;
         end
         clk_en_d[i]  = run_d[i] && (cnt_d[i] == div_d[i]);
         div_clk_d[i] = run_d[i] && ({1'b0, cnt_d[i]} < half_of(div_d[i]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= '0;
         cnt_q     <= '0;
         div_q     <= {NUM_CH{RST_D}};
         shd_q     <= {NUM_CH{RST_D}};
         full_q    <= '0;
         clk_en_q  <= '0;
         div_clk_q <= '0;
      end else begin
         run_q     <= run_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         shd_q     <= shd_d;
         full_q    <= full_d;
         clk_en_q  <= clk_en_d;
         div_clk_q <= div_clk_d;
      end
   end

   assign osc_dis_o   = osc_dis_q;
   assign osc_ready_o = osc_ready_q;
   assign cfg_ready_o = ~full_q;
   assign clk_en_o    = clk_en_q;
   assign div_clk_o   = div_clk_q;

endmodule

// File: tb/tb_osc_clkdiv_mgr.sv
// Directed bench for osc_clkdiv_mgr: expected channel waveforms are queued from the
// period/duty formulas and popped one per clock as the DUT produces them.
module tb_osc_clkdiv_mgr;
   localparam int NUM_CH = 2;
   localparam int DIV_W  = 8;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    stby_req_i = 1'b1;
   logic [NUM_CH-1:0]       ch_en_i = '0;
   logic [NUM_CH-1:0]       cfg_valid_i = '0;
   logic [NUM_CH*DIV_W-1:0] div_cfg_i = '0;
   logic                    osc_dis_o, osc_ready_o;
   logic [NUM_CH-1:0]       cfg_ready_o, clk_en_o, div_clk_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] wave_q[$];   // {clk_en[1], clk_en[0], div_clk[1], div_clk[0]}

   osc_clkdiv_mgr #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .SETTLE_CYC(16), .RESET_DIV(1)) dut (
      .clk(clk), .rst_n(rst_n), .stby_req_i(stby_req_i),
      .osc_dis_o(osc_dis_o), .osc_ready_o(osc_ready_o),
      .ch_en_i(ch_en_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .div_cfg_i(div_cfg_i), .clk_en_o(clk_en_o), .div_clk_o(div_clk_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs for counts c0..c1 of a period with ratio d; both=1 mirrors onto ch1.
   task automatic push_wave(input int d, input int c0, input int c1, input bit both = 1'b0);
      for (int c = c0; c <= c1; c++) begin
         logic en, dc;
         en = (c == d);
         dc = (c < (d + 2) / 2);
         wave_q.push_back({both & en, en, both & dc, dc});
      end
   endtask

   task automatic push_periods(input int d, input int n, input bit both = 1'b0);
      for (int p = 0; p < n; p++) push_wave(d, 0, d, both);
   endtask

   task automatic push_idle(input int n);
      for (int k = 0; k < n; k++) wave_q.push_back(4'b0000);
   endtask

   task automatic consume(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         if (wave_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL wave_underflow: observed %0h expected none queued", {clk_en_o, div_clk_o});
         end else begin
            chk("wave", {30'd0, clk_en_o, div_clk_o} >> 0, {28'd0, wave_q.pop_front()});
         end
      end
   endtask

   task automatic wait_ready(input int limit);
      int k = 0;
      while (!osc_ready_o && k < limit) begin
         step();
         k++;
      end
      chk("ready_timeout", osc_ready_o, 1);
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_osc_dis"},   osc_dis_o,   1);
      chk({p, "_osc_ready"}, osc_ready_o, 0);
      chk({p, "_cfg_ready"}, cfg_ready_o, 2'b11);
      chk({p, "_clk_en"},    clk_en_o,    0);
      chk({p, "_div_clk"},   div_clk_o,   0);
   endtask

   initial begin
      // Reset state
      #12;
      chk_reset("rst");

      // T1: power-up timing
      stby_req_i = 1'b0;
      rst_n      = 1'b1;
      step();
      chk("t1_osc_dis_fall", osc_dis_o, 0);
      chk("t1_ready_low0", osc_ready_o, 0);
      for (int i = 0; i < 15; i++) begin
         step();
         chk("t1_ready_low", osc_ready_o, 0);
      end
      step();
      chk("t1_ready_rise", osc_ready_o, 1);

      // T2: load D=3 into idle ch0, then run
      cfg_valid_i    = 2'b01;
      div_cfg_i[7:0] = 8'd3;
      step();
      cfg_valid_i = '0;
      chk("t2_cfg_busy", cfg_ready_o[0], 0);
      step();
      chk("t2_cfg_idle_apply", cfg_ready_o[0], 1);
      ch_en_i[0] = 1'b1;
      push_periods(3, 3);
      consume(12);

      // T3: D=3 -> 7 mid-period
      push_periods(3, 1);
      push_periods(7, 2);
      consume(1);
      cfg_valid_i    = 2'b01;
      div_cfg_i[7:0] = 8'd7;
      consume(1);
      cfg_valid_i = '0;
      chk("t3_cfg_low", cfg_ready_o[0], 0);
      consume(2);
      chk("t3_cfg_low_boundary", cfg_ready_o[0], 0);
      consume(1);
      chk("t3_cfg_rise", cfg_ready_o[0], 1);
      consume(15);

      // T2: D=4 (3 high / 2 low), then D=0
      push_periods(7, 1);
      push_periods(4, 2);
      consume(1);
      cfg_valid_i    = 2'b01;
      div_cfg_i[7:0] = 8'd4;
      consume(1);
      cfg_valid_i = '0;
      consume(16);
      push_periods(4, 1);
      push_periods(0, 6);
      consume(1);
      cfg_valid_i    = 2'b01;
      div_cfg_i[7:0] = 8'd0;
      consume(1);
      cfg_valid_i = '0;
      consume(9);

      // Transfer on a boundary cycle waits for the following boundary
      push_periods(0, 1);
      push_wave(5, 0, 1);
      cfg_valid_i    = 2'b01;
      div_cfg_i[7:0] = 8'd5;
      consume(1);
      cfg_valid_i = '0;
      chk("bnd_cfg_pending", cfg_ready_o[0], 0);
      consume(1);
      chk("bnd_cfg_rise", cfg_ready_o[0], 1);
      consume(1);

      // T5: disable at cnt=1 with D=5, then re-enable
      ch_en_i[0] = 1'b0;
      push_wave(5, 2, 5);
      push_idle(3);
      consume(7);
      ch_en_i[0] = 1'b1;
      push_periods(5, 1);
      consume(6);

      // T4: D=9, standby at cnt=2 -> 8 DRAIN cycles then OFF
      cfg_valid_i    = 2'b01;
      div_cfg_i[7:0] = 8'd9;
      push_periods(5, 1);
      push_wave(9, 0, 2);
      consume(1);
      cfg_valid_i = '0;
      consume(8);
      stby_req_i = 1'b1;
      push_wave(9, 3, 9);
      push_idle(2);
      for (int i = 1; i <= 9; i++) begin
         consume(1);
         chk("t4_osc_dis", osc_dis_o, (i == 9));
         chk("t4_ready", osc_ready_o, 0);
      end

      // T6: reset mid-RUN with a pending shadow
      stby_req_i = 1'b0;
      ch_en_i    = 2'b11;
      wait_ready(40);
      for (int i = 0; i < 3; i++) step();
      cfg_valid_i    = 2'b01;
      div_cfg_i[7:0] = 8'd2;
      step();
      cfg_valid_i = '0;
      #2 rst_n = 1'b0;
      #1;
      chk_reset("t6_run");

      // Release: both channels restart with RESET_DIV=1
      #2 rst_n = 1'b1;
      wait_ready(40);
      push_periods(1, 3, 1'b1);
      consume(6);

      // T6: reset mid-DRAIN while ch1 runs a long period
      cfg_valid_i     = 2'b10;
      div_cfg_i[15:8] = 8'd20;
      step();
      cfg_valid_i = '0;
      for (int i = 0; i < 3; i++) step();
      stby_req_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("t6_in_drain_dis", osc_dis_o, 0);
      chk("t6_in_drain_ready", osc_ready_o, 0);
      #2 rst_n = 1'b0;
      #1;
      chk_reset("t6_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
